// File: rtl/decoder_seq_nto2n_if.sv
// Command/status bundle for the registered N-to-2^N position decoder.
// The master drives position commands; the slave (decoder) returns the decoded select state.
interface decoder_seq_nto2n_if #(
  parameter int N = 3
);
  localparam int W = 2 ** N;

  logic         En;
  logic         clr;
  logic         load;
  logic [N-1:0] X;
  logic         step;
  logic         dir;
  logic [W-1:0] Y;
  logic [N-1:0] pos;
  logic         active;
  logic         wrap;

  modport master (
    output En, clr, load, X, step, dir,
    input  Y, pos, active, wrap
  );

  modport slave (
    input  En, clr, load, X, step, dir,
    output Y, pos, active, wrap
  );
endinterface

// File: rtl/decoder_seq_nto2n.sv
// Registered one-hot/one-cold decoder with a loadable, up/down wrapping position register.
// One cycle from command edge to Y/pos/wrap; Y is computed from next-state so it never glitches.
module decoder_seq_nto2n #(
  parameter int N          = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  decoder_seq_nto2n_if.slave bus
);
  localparam int W = 2 ** N;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]   state_q;
  logic [0:0]   state_next;
  logic [N-1:0] pos_q;
  logic [N-1:0] pos_next;
  logic         wrap_q;
  logic         wrap_next;
  logic [W-1:0] y_q;
  logic [W-1:0] y_next;
  logic [W-1:0] onehot;

  always_comb begin
    state_next = state_q;
    pos_next   = pos_q;
    wrap_next  = 1'b0;
    if (bus.clr) begin
      state_next = ST_IDLE;
      pos_next   = '0;
    end else if (bus.load) begin
      state_next = ST_ACTIVE;
      pos_next   = bus.X;
    end else if (bus.step && (state_q == ST_ACTIVE)) begin
      // N-bit arithmetic wraps naturally; wrap flags the boundary crossing
      if (!bus.dir) begin
        pos_next  = pos_q + 1'b1;
        wrap_next = (pos_q == {N{1'b1}});
      end else begin
        pos_next  = pos_q - 1'b1;
        wrap_next = (pos_q == '0);
      end
    end
  end

  always_comb begin
    onehot           = '0;
    onehot[pos_next] = 1'b1;
    y_next           = (bus.En && (state_next == ST_ACTIVE)) ? onehot : '0;
    if (ACTIVE_LOW) begin
      y_next = ~y_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= {W{ACTIVE_LOW}};
    end else begin
      state_q <= state_next;
      pos_q   <= pos_next;
      wrap_q  <= wrap_next;
      y_q     <= y_next;
    end
  end

  assign bus.Y      = y_q;
  assign bus.pos    = pos_q;
  assign bus.active = (state_q == ST_ACTIVE);
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// Drives four decoder configurations with identical commands and checks each against an arithmetic model.
module tb_decoder_seq_nto2n;
  logic clk;
  logic rst;

  decoder_seq_nto2n_if #(.N(3)) if0 ();
  decoder_seq_nto2n_if #(.N(3)) if1 ();
  decoder_seq_nto2n_if #(.N(1)) if2 ();
  decoder_seq_nto2n_if #(.N(4)) if3 ();

  decoder_seq_nto2n #(.N(3), .ACTIVE_LOW(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  decoder_seq_nto2n #(.N(3), .ACTIVE_LOW(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  decoder_seq_nto2n #(.N(1), .ACTIVE_LOW(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  decoder_seq_nto2n #(.N(4), .ACTIVE_LOW(1'b0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [31:0] oy [4];
  logic [31:0] op [4];
  logic [31:0] oa [4];
  logic [31:0] ow [4];

  assign oy[0] = 32'(if0.Y);   assign op[0] = 32'(if0.pos);
  assign oy[1] = 32'(if1.Y);   assign op[1] = 32'(if1.pos);
  assign oy[2] = 32'(if2.Y);   assign op[2] = 32'(if2.pos);
  assign oy[3] = 32'(if3.Y);   assign op[3] = 32'(if3.pos);
  assign oa[0] = 32'(if0.active); assign ow[0] = 32'(if0.wrap);
  assign oa[1] = 32'(if1.active); assign ow[1] = 32'(if1.wrap);
  assign oa[2] = 32'(if2.active); assign ow[2] = 32'(if2.wrap);
  assign oa[3] = 32'(if3.active); assign ow[3] = 32'(if3.wrap);

  int nbits [4] = '{3, 3, 1, 4};
  int pol   [4] = '{0, 1, 0, 0};
  int mpos  [4];
  int mact  [4];
  int mwrap [4];
  int my    [4];

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_i%0d_Y", tag, k),      oy[k], 32'(my[k]));
      chk($sformatf("%s_i%0d_pos", tag, k),    op[k], 32'(mpos[k]));
      chk($sformatf("%s_i%0d_active", tag, k), oa[k], 32'(mact[k]));
      chk($sformatf("%s_i%0d_wrap", tag, k),   ow[k], 32'(mwrap[k]));
    end
  endtask

  function automatic int out_of(int k, int en);
    int w    = 1 << nbits[k];
    int mask = (1 << w) - 1;
    int v    = (en != 0 && mact[k] != 0) ? (1 << mpos[k]) : 0;
    return (pol[k] != 0) ? (~v & mask) : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mpos[k] = 0; mact[k] = 0; mwrap[k] = 0;
      my[k] = out_of(k, 0);
    end
  endtask

  task automatic model_step(input int en, input int c, input int ld, input int x,
                            input int st, input int d);
    for (int k = 0; k < 4; k++) begin
      int w = 1 << nbits[k];
      mwrap[k] = 0;
      if (c != 0) begin
        mpos[k] = 0; mact[k] = 0;
      end else if (ld != 0) begin
        mpos[k] = x % w; mact[k] = 1;
      end else if (st != 0 && mact[k] != 0) begin
        int np = (d != 0) ? (mpos[k] + w - 1) % w : (mpos[k] + 1) % w;
        mwrap[k] = (d != 0) ? int'(mpos[k] == 0) : int'(mpos[k] == w - 1);
        mpos[k]  = np;
      end
      my[k] = out_of(k, en);
    end
  endtask

  task automatic set_in(input int en, input int c, input int ld, input int x,
                        input int st, input int d);
    logic [3:0] xv;
    xv = 4'(x);
    if0.En = en[0]; if1.En = en[0]; if2.En = en[0]; if3.En = en[0];
    if0.clr = c[0]; if1.clr = c[0]; if2.clr = c[0]; if3.clr = c[0];
    if0.load = ld[0]; if1.load = ld[0]; if2.load = ld[0]; if3.load = ld[0];
    if0.step = st[0]; if1.step = st[0]; if2.step = st[0]; if3.step = st[0];
    if0.dir = d[0]; if1.dir = d[0]; if2.dir = d[0]; if3.dir = d[0];
    if0.X = xv[2:0]; if1.X = xv[2:0]; if2.X = xv[0:0]; if3.X = xv;
  endtask

  task automatic cycle(input string tag, input int en, input int c, input int ld,
                       input int x, input int st, input int d);
    set_in(en, c, ld, x, st, d);
    @(posedge clk);
    model_step(en, c, ld, x, st, d);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_now"});
    @(posedge clk);
    #1;
    check_all({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_in(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst = 1'b0;

    for (int x = 0; x < 16; x++) cycle("load_sweep", 1, 0, 1, x, 0, 0);

    cycle("up_load6", 1, 0, 1, 6, 0, 0);
    for (int i = 0; i < 3; i++) cycle("up_step", 1, 0, 0, 0, 1, 0);
    cycle("dn_load1", 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle("dn_step", 1, 0, 0, 0, 1, 1);
    cycle("clr", 1, 1, 0, 0, 0, 0);
    cycle("idle_step_up", 1, 0, 0, 0, 1, 0);
    cycle("idle_step_dn", 1, 0, 0, 0, 1, 1);

    cycle("en0_load5", 0, 0, 1, 5, 0, 0);
    cycle("en0_step", 0, 0, 0, 0, 1, 0);
    cycle("en_raise", 1, 0, 0, 0, 0, 0);
    cycle("load_beats_step", 1, 0, 1, 2, 1, 0);
    cycle("clr_beats_load", 1, 1, 1, 7, 0, 0);
    cycle("hold_idle", 1, 0, 0, 0, 0, 0);

    cycle("pol_load3", 1, 0, 1, 3, 0, 0);
    async_reset("mid_rst");
    cycle("post_rst_load", 1, 0, 1, 9, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle("rnd",
            int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
      if (i == 200) async_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
